// File: rtl/ebox_mem_port.sv
// ebox_mem_port: turns EBOX read, write and read-pause-write requests into
// single-word transactions on the physical memory port. It returns the
// accept, retry and completion handshakes to the EBOX. It also flags a
// memory that never answers (nxmErr) and bad read parity (mbParErr).
module ebox_mem_port #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic          clk,
   input  logic          resetN,
   input  logic          eboxReq,
   input  logic [13:35]  eboxVMA,
   input  logic          eboxRead,
   input  logic          eboxWrite,
   input  logic          eboxPSE,
   input  logic [0:35]   eboxWrData,
   output logic          cshEBOXT0,
   output logic          cshEBOXRetry,
   output logic          mboxRespIn,
   output logic [0:35]   cacheData,
   output logic          mbParErr,
   output logic          nxmErr,
   output logic          memReq,
   output logic          memWrite,
   output logic [14:35]  memAdr,
   output logic [0:35]   memWrData,
   input  logic          memBusy,
   input  logic          memAck,
   input  logic [0:35]   memRdData,
   input  logic          memRdPar
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP,
      PAUSE
   } state_t;

   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

   state_t        state;
   logic [14:35]  held_adr;     // word address of the current transaction
   logic [0:35]   held_data;    // write data sampled at acceptance
   logic          is_write;     // current transaction is a write cycle
   logic          pse_read;     // read half of a read-pause-write still pending its write
   logic          pse_write;    // write half of a read-pause-write; a busy refusal returns to PAUSE
   logic [7:0]    tmo_count;    // cycles spent in WAIT without memAck
   logic          par_odd;      // 1 when data plus parity bit has odd parity
   logic          unused_vma_bit;

   // Bit 13 of the virtual address does not take part in the physical address.
   assign unused_vma_bit = eboxVMA[13];

   // Odd parity over the 36 data bits and the parity bit.
   assign par_odd = ^{memRdData, memRdPar};

   // Transaction sequencer; every EBOX and memory output is registered here.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         state        <= IDLE;
         held_adr     <= '0;
         held_data    <= '0;
         is_write     <= 1'b0;
         pse_read     <= 1'b0;
         pse_write    <= 1'b0;
         tmo_count    <= '0;
         cshEBOXT0    <= 1'b0;
         cshEBOXRetry <= 1'b0;
         mboxRespIn   <= 1'b0;
         cacheData    <= '0;
         mbParErr     <= 1'b0;
         nxmErr       <= 1'b0;
         memReq       <= 1'b0;
         memWrite     <= 1'b0;
         memAdr       <= '0;
         memWrData    <= '0;
      end else begin
         // Handshake outputs are single-cycle pulses unless set again below.
         cshEBOXT0    <= 1'b0;
         cshEBOXRetry <= 1'b0;
         mboxRespIn   <= 1'b0;
         mbParErr     <= 1'b0;
         nxmErr       <= 1'b0;

         case (state)
            IDLE: begin
               if (eboxReq && (eboxRead || eboxWrite)) begin
                  held_adr  <= eboxVMA[14:35];
                  held_data <= eboxWrData;
                  // A request that claims both types is treated as a read.
                  is_write  <= eboxWrite && !eboxRead;
                  pse_read  <= eboxRead && eboxPSE;
                  pse_write <= 1'b0;
                  cshEBOXT0 <= 1'b1;
                  state     <= ISSUE;
               end
            end

            ISSUE: begin
               if (memBusy) begin
                  cshEBOXRetry <= 1'b1;
                  state        <= pse_write ? PAUSE : IDLE;
               end else begin
                  memReq    <= 1'b1;
                  memWrite  <= is_write;
                  memAdr    <= held_adr;
                  memWrData <= held_data;
                  tmo_count <= '0;
                  state     <= WAIT;
               end
            end

            WAIT: begin
               // memAck takes priority over a timeout that expires in the same cycle.
               if (memAck) begin
                  memReq     <= 1'b0;
                  mboxRespIn <= 1'b1;
                  if (!is_write) begin
                     cacheData <= memRdData;
                     mbParErr  <= !par_odd;
                  end
                  state <= RESP;
               end else if (tmo_count == TMO_LIMIT) begin
                  memReq     <= 1'b0;
                  mboxRespIn <= 1'b1;
                  nxmErr     <= 1'b1;
                  cacheData  <= '0;
                  pse_read   <= 1'b0;
                  state      <= RESP;
               end else begin
                  tmo_count <= tmo_count + 8'd1;
               end
            end

            RESP: begin
               state <= (pse_read && !is_write) ? PAUSE : IDLE;
            end

            PAUSE: begin
               if (eboxReq) begin
                  if (eboxWrite) begin
                     // The write reuses the held address of the preceding read.
                     held_data <= eboxWrData;
                     is_write  <= 1'b1;
                     pse_read  <= 1'b0;
                     pse_write <= 1'b1;
                     cshEBOXT0 <= 1'b1;
                     state     <= ISSUE;
                  end else begin
                     cshEBOXRetry <= 1'b1;
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ebox_mem_port.sv
// tb_ebox_mem_port: directed and randomized transactions against
// ebox_mem_port. A transaction-level model predicts the cycle of every
// handshake, the error flags, cacheData and the PAUSE state.
module tb_ebox_mem_port;

   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          resetN;
   logic          eboxReq;
   logic [13:35]  eboxVMA;
   logic          eboxRead;
   logic          eboxWrite;
   logic          eboxPSE;
   logic [0:35]   eboxWrData;
   logic          cshEBOXT0;
   logic          cshEBOXRetry;
   logic          mboxRespIn;
   logic [0:35]   cacheData;
   logic          mbParErr;
   logic          nxmErr;
   logic          memReq;
   logic          memWrite;
   logic [14:35]  memAdr;
   logic [0:35]   memWrData;
   logic          memBusy;
   logic          memAck;
   logic [0:35]   memRdData;
   logic          memRdPar;

   int            checks = 0;
   int            errors = 0;
   int            txn_no = 0;

   // reference model state
   logic [0:35]   exp_cache;
   logic          in_pause;
   logic [14:35]  pause_adr;

   ebox_mem_port #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk          (clk),
      .resetN       (resetN),
      .eboxReq      (eboxReq),
      .eboxVMA      (eboxVMA),
      .eboxRead     (eboxRead),
      .eboxWrite    (eboxWrite),
      .eboxPSE      (eboxPSE),
      .eboxWrData   (eboxWrData),
      .cshEBOXT0    (cshEBOXT0),
      .cshEBOXRetry (cshEBOXRetry),
      .mboxRespIn   (mboxRespIn),
      .cacheData    (cacheData),
      .mbParErr     (mbParErr),
      .nxmErr       (nxmErr),
      .memReq       (memReq),
      .memWrite     (memWrite),
      .memAdr       (memAdr),
      .memWrData    (memWrData),
      .memBusy      (memBusy),
      .memAck       (memAck),
      .memRdData    (memRdData),
      .memRdPar     (memRdPar)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic good_par(input logic [0:35] d);
      return ~(^d);
   endfunction

   function automatic logic [0:35] rnd36();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[35:0];
   endfunction

   task automatic check_quiet(input string tag);
      check({tag, "_t0"},    cshEBOXT0,    1'b0);
      check({tag, "_retry"}, cshEBOXRetry, 1'b0);
      check({tag, "_resp"},  mboxRespIn,   1'b0);
      check({tag, "_nxm"},   nxmErr,       1'b0);
      check({tag, "_par"},   mbParErr,     1'b0);
   endtask

   // op: 0 read, 1 write, 2 read-pause-write read half.
   // busy_n: number of memBusy refusals before the issue succeeds.
   // ack_dly: memAck this many cycles after memReq first rises; > TMO never acks.
   task automatic run_txn(input int op, input logic [13:35] vma, input logic [0:35] wdata,
                          input int busy_n, input int ack_dly,
                          input logic [0:35] rdata, input logic par, input logic stray_ack);
      logic          is_wr;
      logic          exp_nxm;
      logic          exp_par;
      logic [14:35]  exp_adr;
      txn_no++;
      is_wr = (op == 1);
      eboxRead  = (op != 1);
      eboxWrite = (op == 1);
      eboxPSE   = (op == 2);
      eboxVMA   = vma;
      eboxWrData = wdata;

      if (in_pause && !is_wr) begin
         // Only the write half is accepted in PAUSE; anything else is refused.
         eboxReq = 1'b1;
         memAck  = stray_ack;
         tick();
         memAck  = 1'b0;
         eboxReq = 1'b0;
         check("pause_retry", cshEBOXRetry, 1'b1);
         check("pause_no_t0", cshEBOXT0, 1'b0);
         check("pause_no_memreq", memReq, 1'b0);
         tick();
         check("pause_retry_pulse", cshEBOXRetry, 1'b0);
         check("pause_still_no_t0", cshEBOXT0, 1'b0);
         $display("txn %0d op=%0d refused in PAUSE", txn_no, op);
         return;
      end

      exp_adr = in_pause ? pause_adr : vma[14:35];

      for (int b = 0; b <= busy_n; b++) begin
         eboxReq = 1'b1;
         memAck  = (b == 0) ? stray_ack : 1'b0;
         tick();
         memAck  = 1'b0;
         check("t0", cshEBOXT0, 1'b1);
         check("t0_no_memreq", memReq, 1'b0);
         eboxReq = 1'b0;
         memBusy = (b < busy_n);
         tick();
         memBusy = 1'b0;
         if (b < busy_n) begin
            check("busy_retry", cshEBOXRetry, 1'b1);
            check("busy_no_memreq", memReq, 1'b0);
            check("busy_no_t0", cshEBOXT0, 1'b0);
         end
      end

      check("memreq_rise", memReq, 1'b1);
      check("memwrite", memWrite, is_wr);
      check("memadr", memAdr, exp_adr);
      if (is_wr) check("memwrdata", memWrData, wdata);
      check("issue_no_retry", cshEBOXRetry, 1'b0);

      for (int k = 0; k <= TMO; k++) begin
         check("wait_memreq", memReq, 1'b1);
         check("wait_no_resp", mboxRespIn, 1'b0);
         if (k == ack_dly) begin
            memAck    = 1'b1;
            memRdData = rdata;
            memRdPar  = par;
         end else begin
            memRdData = rnd36();
            memRdPar  = 1'($urandom_range(0, 1));
         end
         tick();
         memAck = 1'b0;
         if (k == ack_dly) break;
      end

      exp_nxm = (ack_dly > TMO);
      exp_par = !exp_nxm && !is_wr && ((^{rdata, par}) == 1'b0);
      if (exp_nxm)     exp_cache = '0;
      else if (!is_wr) exp_cache = rdata;

      check("resp", mboxRespIn, 1'b1);
      check("resp_nxm", nxmErr, exp_nxm);
      check("resp_par", mbParErr, exp_par);
      check("resp_memreq_low", memReq, 1'b0);
      check("resp_cache", cacheData, exp_cache);

      in_pause = (op == 2) && !exp_nxm;
      if (in_pause) pause_adr = exp_adr;

      tick();
      check("after_resp_quiet", mboxRespIn, 1'b0);
      check("after_nxm_quiet", nxmErr, 1'b0);
      check("after_par_quiet", mbParErr, 1'b0);
      check("after_memreq", memReq, 1'b0);
      check("after_cache", cacheData, exp_cache);
      $display("txn %0d op=%0d adr=%o busy=%0d ack=%0d nxm=%0d par=%0d cache=%o",
               txn_no, op, exp_adr, busy_n, ack_dly, exp_nxm, exp_par, exp_cache);
   endtask

   initial begin
      logic [0:35] d;
      resetN     = 1'b0;
      eboxReq    = 1'b0;
      eboxVMA    = '0;
      eboxRead   = 1'b0;
      eboxWrite  = 1'b0;
      eboxPSE    = 1'b0;
      eboxWrData = '0;
      memBusy    = 1'b0;
      memAck     = 1'b0;
      memRdData  = '0;
      memRdPar   = 1'b0;
      exp_cache  = '0;
      in_pause   = 1'b0;
      pause_adr  = '0;

      tick();
      tick();
      check_quiet("reset");
      check("reset_memreq", memReq, 1'b0);
      check("reset_cache", cacheData, 36'd0);
      check("reset_memadr", memAdr, 22'd0);
      check("reset_memwrdata", memWrData, 36'd0);
      resetN = 1'b1;
      tick();
      check_quiet("post_reset");

      // basic read: ack 3 cycles after memReq, good parity
      d = 36'o123456701234;
      run_txn(0, 23'o000100, 36'd0, 0, 3, d, good_par(d), 1'b0);
      // write: cacheData must keep the read value
      run_txn(1, 23'o000200, 36'o777777000000, 0, 2, rnd36(), 1'b0, 1'b0);
      // busy refusal then a normal read
      d = 36'o000000777777;
      run_txn(0, 23'o001234, 36'd0, 1, 1, d, good_par(d), 1'b0);
      // no response: nxm, cacheData cleared
      run_txn(0, 23'o004000, 36'd0, 0, TMO + 5, d, good_par(d), 1'b0);
      // ack on the last cycle before timeout: no nxm
      d = 36'o707070707070;
      run_txn(0, 23'o004001, 36'd0, 0, TMO, d, good_par(d), 1'b0);
      // read-pause-write with bad parity, refused read, write to held address
      d = 36'o111122223333;
      run_txn(2, 23'o000300, 36'd0, 0, 1, d, ~good_par(d), 1'b1);
      run_txn(0, 23'o000400, 36'd0, 0, 1, d, 1'b0, 1'b0);
      run_txn(1, 23'o017777, 36'o555555555555, 1, 2, rnd36(), 1'b0, 1'b1);
      // read-pause-write that times out cancels the pause
      run_txn(2, 23'o000500, 36'd0, 0, TMO + 1, d, 1'b0, 1'b0);
      d = 36'o246024602460;
      run_txn(0, 23'o000600, 36'd0, 0, 1, d, good_par(d), 1'b0);

      // randomized transactions
      for (int i = 0; i < 40; i++) begin
         logic [0:35] rd;
         rd = rnd36();
         run_txn(int'($urandom_range(0, 2)), 23'($urandom()), rnd36(),
                 int'($urandom_range(0, 2)), int'($urandom_range(1, TMO + 3)),
                 rd, ($urandom_range(0, 3) == 0) ? ~good_par(rd) : good_par(rd),
                 1'($urandom_range(0, 1)));
      end

      // reset while memReq is high; a late memAck must be ignored
      in_pause = 1'b0;
      eboxRead = 1'b1; eboxWrite = 1'b0; eboxPSE = 1'b0;
      eboxVMA  = 23'o000700;
      eboxReq  = 1'b1;
      tick();
      // in PAUSE from the random phase a read is refused instead of accepted
      eboxReq  = 1'b0;
      if (cshEBOXT0 === 1'b1) begin
         tick();
         check("midreset_memreq_high", memReq, 1'b1);
      end
      resetN = 1'b0;
      tick();
      check("midreset_memreq", memReq, 1'b0);
      check("midreset_cache", cacheData, 36'd0);
      check("midreset_memadr", memAdr, 22'd0);
      check("midreset_memwrdata", memWrData, 36'd0);
      check_quiet("midreset");
      resetN = 1'b1;
      memAck = 1'b1;
      memRdData = 36'o123123123123;
      tick();
      memAck = 1'b0;
      tick();
      check("late_ack_resp", mboxRespIn, 1'b0);
      check("late_ack_memreq", memReq, 1'b0);
      check("late_ack_cache", cacheData, 36'd0);
      exp_cache = '0;
      in_pause  = 1'b0;
      d = 36'o765432107654;
      run_txn(0, 23'o000010, 36'd0, 0, 2, d, good_par(d), 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
